// File: rtl/sd_fifo_head_bc.sv
// Write-side controller for memory-based "B" FIFOs in a bounded region of a shared RAM.
// Optional commit/abort support: define SD_FIFO_HEAD_COMMIT_EN.
module sd_fifo_head_bc #(
   parameter int width = 8,
   parameter int depth = 16,
   parameter int asz   = $clog2(depth)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [asz-1:0]   bound_low,
   input  logic [asz-1:0]   bound_high,
   input  logic [asz-1:0]   rdptr,
   input  logic             c_srdy,
   output logic             c_drdy,
   input  logic [width-1:0] c_data,
   input  logic             c_commit,
   input  logic             c_abort,
   output logic [asz-1:0]   cur_wrptr,
   output logic [asz-1:0]   com_wrptr,
   output logic             mem_we,
   output logic [width-1:0] mem_wr_data,
   output logic [asz:0]     usage
);

   logic [asz-1:0] r_cur_wrptr;
   logic [asz-1:0] w_cur_wrptr_p1;
   logic           w_full;
   logic           w_abort_act;
   logic           w_we;
   logic [asz:0]   w_tmp;
   logic [asz:0]   w_span;
   logic [asz:0]   w_back;

   always_comb begin
      w_cur_wrptr_p1 = (r_cur_wrptr == bound_high) ? bound_low : r_cur_wrptr + asz'(1);
      w_full         = (w_cur_wrptr_p1 == rdptr);
      // Reset is folded in so no write strobe can escape while pointers are held.
      c_drdy         = enable & ~w_full & ~w_abort_act & ~reset;
      w_we           = c_srdy & c_drdy;
      mem_we         = w_we;
      mem_wr_data    = c_data;
      cur_wrptr      = r_cur_wrptr;
   end

   // A borrow means the write pointer has wrapped past bound_high relative to rdptr.
   always_comb begin
      w_tmp  = {1'b0, r_cur_wrptr} - {1'b0, rdptr};
      w_span = {1'b0, bound_high} - {1'b0, bound_low} + (asz+1)'(1);
      w_back = {1'b0, rdptr} - {1'b0, r_cur_wrptr};
      usage  = w_tmp[asz] ? (w_span - w_back) : w_tmp;
   end

`ifdef SD_FIFO_HEAD_COMMIT_EN
   logic [asz-1:0] r_com_wrptr;

   always_comb begin
      w_abort_act = c_abort;
      com_wrptr   = r_com_wrptr;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cur_wrptr <= bound_low;
         r_com_wrptr <= bound_low;
      end else if (w_abort_act) begin
         r_cur_wrptr <= r_com_wrptr;
      end else begin
         if (w_we)
            r_cur_wrptr <= w_cur_wrptr_p1;
         if (c_commit)
            r_com_wrptr <= w_we ? w_cur_wrptr_p1 : r_cur_wrptr;
      end
   end
`else
   logic w_unused_ctl;

   always_comb begin
      w_abort_act  = 1'b0;
      com_wrptr    = r_cur_wrptr;
      w_unused_ctl = c_commit ^ c_abort;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_cur_wrptr <= bound_low;
      else if (w_we)
         r_cur_wrptr <= w_cur_wrptr_p1;
   end
`endif

endmodule
